lsu_exec: RTL and testbench

Load/store execution unit on the consumer side of the issue queue's MEM issue port. It accepts one memory micro-op at a time through a valid/ready handshake and computes the effective address. It performs the access on a variable-latency data-memory port. Load results are broadcast on the CDB through a request/grant arbiter, and every instruction's completion is reported to the ROB.

---
 rtl/lsu_exec.sv | 167 ++++++++++++++++
 tb/tb_lsu_exec.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_exec.sv
// Load/store execution unit: takes one memory micro-op from the MEM issue port, performs the
// access on a variable-latency data port, broadcasts load results on the CDB and reports completion.
module lsu_exec #(
   parameter int XLEN = 32,
   parameter int TAGW = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_issue_valid,
   input  logic [TAGW-1:0] mem_rd,
   input  logic [TAGW-1:0] mem_rob_num,
   input  logic [XLEN-1:0] mem_scr1_data,
   input  logic [XLEN-1:0] mem_scr2_data,
   input  logic [XLEN-1:0] mem_imm,
   input  logic            mem_rd_en,
   input  logic            mem_wr_en,
   input  logic [1:0]      mem_size,
   input  logic            mem_reg_write,
   output logic            mem2iq_ready,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            cdb_req,
   input  logic            cdb_gnt,
   output logic [TAGW-1:0] cdb_tag,
   output logic [XLEN-1:0] cdb_data,
   output logic            lsu2rob_done,
   output logic [TAGW-1:0] lsu2rob_num,
   output logic            lsu2rob_exc
);

   typedef enum logic [1:0] {IDLE, MEM, WB, DONE} state_t;

   state_t                 state_q, state_d;
   logic [XLEN-1:0]        ea;
   logic                   accept, has_access, mis;

   logic [XLEN-1:0]        addr_p1, wdata_p1;
   logic [3:0]             be_p1;
   logic                   we_p1, exc_p1, wb_p1;
   logic [TAGW-1:0]        rob_p1, tag_p1;
   logic [1:0]             size_p1, lane_p1;
   logic signed [XLEN-1:0] cdb_data_p2;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return lane[0];
         default: return lane != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
      case (size)
         2'b00:   return {(XLEN/8){data[7:0]}};
         2'b01:   return {(XLEN/16){data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic signed [XLEN-1:0] load_ext(input logic [1:0] size, input logic [1:0] lane,
                                                       input logic [XLEN-1:0] word);
      logic [XLEN-1:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   load_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
         2'b01:   load_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
         default: load_ext = word;
      endcase
   endfunction

   assign ea         = mem_scr1_data + mem_imm;
   assign accept     = mem_issue_valid && (state_q == IDLE);
   assign has_access = mem_rd_en | mem_wr_en;
   assign mis        = has_access & misaligned(mem_size, ea[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // p1: operand fields latched at accept; p2: load result captured on ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_p1     <= '0;
         be_p1       <= '0;
         wdata_p1    <= '0;
         we_p1       <= 1'b0;
         exc_p1      <= 1'b0;
         wb_p1       <= 1'b0;
         rob_p1      <= '0;
         tag_p1      <= '0;
         cdb_data_p2 <= '0;
      end else begin
         if (accept) begin
            addr_p1  <= {ea[XLEN-1:2], 2'b00};
            be_p1    <= lane_be(mem_size, ea[1:0]);
            wdata_p1 <= lane_wdata(mem_size, mem_scr2_data);
            we_p1    <= mem_wr_en;
            exc_p1   <= mis;
            wb_p1    <= mem_rd_en & ~mem_wr_en & mem_reg_write;
            rob_p1   <= mem_rob_num;
            tag_p1   <= mem_rd;
         end
         if (state_q == MEM && dmem_ack && wb_p1)
            cdb_data_p2 <= load_ext(size_p1, lane_p1, dmem_rdata);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         size_p1 <= mem_size;
         lane_p1 <= ea[1:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      mem2iq_ready = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      cdb_req      = 1'b0;
      lsu2rob_done = 1'b0;
      lsu2rob_exc  = 1'b0;
      case (state_q)
         IDLE: begin
            mem2iq_ready = 1'b1;
            if (accept) state_d = (mis || !has_access) ? DONE : MEM;
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = we_p1;
            if (dmem_ack) state_d = wb_p1 ? WB : DONE;
         end
         WB: begin
            cdb_req = 1'b1;
            if (cdb_gnt) state_d = DONE;
         end
         DONE: begin
            lsu2rob_done = 1'b1;
            lsu2rob_exc  = exc_p1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dmem_addr   = addr_p1;
   assign dmem_be     = be_p1;
   assign dmem_wdata  = wdata_p1;
   assign cdb_tag     = tag_p1;
   assign cdb_data    = cdb_data_p2;
   assign lsu2rob_num = rob_p1;

endmodule

// File: tb/tb_lsu_exec.sv
// Bench for lsu_exec: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the unit's bus behaviour.
module tb_lsu_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_issue_valid;
   logic [5:0]  mem_rd, mem_rob_num;
   logic [31:0] mem_scr1_data, mem_scr2_data, mem_imm;
   logic        mem_rd_en, mem_wr_en, mem_reg_write;
   logic [1:0]  mem_size;
   logic        mem2iq_ready;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        cdb_req, cdb_gnt;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        lsu2rob_done;
   logic [5:0]  lsu2rob_num;
   logic        lsu2rob_exc;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;

   lsu_exec #(.XLEN(32), .TAGW(6)) dut (
      .clk(clk), .rst(rst),
      .mem_issue_valid(mem_issue_valid), .mem_rd(mem_rd), .mem_rob_num(mem_rob_num),
      .mem_scr1_data(mem_scr1_data), .mem_scr2_data(mem_scr2_data), .mem_imm(mem_imm),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_size(mem_size),
      .mem_reg_write(mem_reg_write), .mem2iq_ready(mem2iq_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .lsu2rob_done(lsu2rob_done), .lsu2rob_num(lsu2rob_num), .lsu2rob_exc(lsu2rob_exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz, input int lane);
      int unsigned v;
      v = w / (32'd1 << (8 * lane));
      if (sz == 2'd0) return (v % 256 >= 128) ? 32'(v % 256) - 32'd256 : 32'(v % 256);
      if (sz == 2'd1) return (v % 65536 >= 32768) ? 32'(v % 65536) - 32'd65536 : 32'(v % 65536);
      return w;
   endfunction

   // phase of the in-flight op: 0 none, 1 memory access, 2 CDB broadcast, 3 completion
   int          ph = 0;
   logic [31:0] e_addr, e_wdata, e_cdb;
   logic [3:0]  e_be;
   logic        e_we, e_exc, e_wb;
   logic [5:0]  e_tag, e_num;
   logic [1:0]  e_sz;
   int          e_lane;

   always @(negedge clk) begin
      if (rst) ph = 0;
      else begin
         case (ph)
            0: begin
               chk("idle_ready", mem2iq_ready, 1);
               chk("idle_req", dmem_req, 0);
               chk("idle_cdb", cdb_req, 0);
               chk("idle_done", lsu2rob_done, 0);
               if (mem_issue_valid) begin
                  logic [31:0] ea;
                  logic        acc, mis;
                  ea     = mem_scr1_data + mem_imm;
                  e_lane = int'(ea % 4);
                  e_sz   = mem_size;
                  acc    = mem_rd_en || mem_wr_en;
                  mis    = (mem_size == 2'd1) ? (ea % 2 != 0) : (mem_size >= 2'd2) ? (ea % 4 != 0) : 1'b0;
                  e_exc  = acc && mis;
                  e_addr = ea - ea % 4;
                  e_be   = (mem_size == 2'd0) ? 4'(1 << e_lane) : (mem_size == 2'd1) ? 4'(3 << e_lane) : 4'hF;
                  e_wdata = (mem_size == 2'd0) ? mem_scr2_data[7:0] * 32'h01010101 :
                            (mem_size == 2'd1) ? mem_scr2_data[15:0] * 32'h00010001 : mem_scr2_data;
                  e_we   = mem_wr_en;
                  e_wb   = mem_rd_en && !mem_wr_en && mem_reg_write;
                  e_tag  = mem_rd;
                  e_num  = mem_rob_num;
                  ph     = (acc && !mis) ? 1 : 3;
               end
            end
            1: begin
               chk("mem_ready", mem2iq_ready, 0);
               chk("mem_req", dmem_req, 1);
               chk("mem_addr", dmem_addr, e_addr);
               chk("mem_be", dmem_be, e_be);
               chk("mem_wdata", dmem_wdata, e_wdata);
               chk("mem_we", dmem_we, e_we);
               chk("mem_cdb", cdb_req, 0);
               chk("mem_done", lsu2rob_done, 0);
               if (dmem_ack) begin
                  e_cdb = m_load(dmem_rdata, e_sz, e_lane);
                  ph    = e_wb ? 2 : 3;
               end
            end
            2: begin
               chk("wb_ready", mem2iq_ready, 0);
               chk("wb_req", dmem_req, 0);
               chk("wb_cdb", cdb_req, 1);
               chk("wb_tag", cdb_tag, e_tag);
               chk("wb_data", cdb_data, e_cdb);
               chk("wb_done", lsu2rob_done, 0);
               if (cdb_gnt) ph = 3;
            end
            default: begin
               chk("dn_done", lsu2rob_done, 1);
               chk("dn_num", lsu2rob_num, e_num);
               chk("dn_exc", lsu2rob_exc, e_exc);
               chk("dn_ready", mem2iq_ready, 0);
               chk("dn_req", dmem_req, 0);
               chk("dn_cdb", cdb_req, 0);
               n_done++;
               ph = 0;
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [31:0] s1, input logic [31:0] imm, input logic [31:0] s2,
                           input logic [1:0] sz, input logic rd, input logic wr, input logic rw,
                           input logic [5:0] tag, input logic [5:0] rob);
      mem_scr1_data = s1; mem_imm = imm; mem_scr2_data = s2; mem_size = sz;
      mem_rd_en = rd; mem_wr_en = wr; mem_reg_write = rw; mem_rd = tag; mem_rob_num = rob;
      mem_issue_valid = 1'b1;
   endtask

   initial begin
      int done_before;
      rst = 1'b1;
      mem_issue_valid = 0; mem_rd = 0; mem_rob_num = 0; mem_scr1_data = 0; mem_scr2_data = 0;
      mem_imm = 0; mem_rd_en = 0; mem_wr_en = 0; mem_size = 0; mem_reg_write = 0;
      dmem_ack = 0; dmem_rdata = 0; cdb_gnt = 0;
      #1;
      chk("rst_ready", mem2iq_ready, 1);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_be", dmem_be, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_cdb", cdb_req, 0);
      chk("rst_tag", cdb_tag, 0);
      chk("rst_cdata", cdb_data, 0);
      chk("rst_done", lsu2rob_done, 0);
      chk("rst_num", lsu2rob_num, 0);
      chk("rst_exc", lsu2rob_exc, 0);
      step(); step();
      rst = 1'b0;
      step();

      // word load, ack after 3 MEM cycles, grant after 2 waiting cycles
      drive_op(32'h100, 32'd4, 32'h0, 2'b10, 1, 0, 1, 6'd7, 6'd3);
      step();
      mem_issue_valid = 0;
      chk("wl_req", dmem_req, 1);
      chk("wl_addr", dmem_addr, 32'h104);
      chk("wl_be", dmem_be, 4'b1111);
      chk("wl_we", dmem_we, 0);
      step(); step();
      chk("wl_hold_addr", dmem_addr, 32'h104);
      dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
      step();
      dmem_ack = 0;
      chk("wl_cdb", cdb_req, 1);
      chk("wl_tag", cdb_tag, 7);
      chk("wl_data", cdb_data, 32'hDEADBEEF);
      step(); step();
      chk("wl_hold_data", cdb_data, 32'hDEADBEEF);
      cdb_gnt = 1;
      step();
      cdb_gnt = 0;
      chk("wl_done", lsu2rob_done, 1);
      chk("wl_num", lsu2rob_num, 3);
      chk("wl_exc", lsu2rob_exc, 0);
      step();
      chk("wl_ready", mem2iq_ready, 1);

      // byte store to lane 3, immediate ack
      drive_op(32'h203, 32'd0, 32'h000000A5, 2'b00, 0, 1, 0, 6'd1, 6'd4);
      step();
      mem_issue_valid = 0;
      chk("bs_addr", dmem_addr, 32'h200);
      chk("bs_be", dmem_be, 4'b1000);
      chk("bs_wdata", dmem_wdata, 32'hA5A5A5A5);
      chk("bs_we", dmem_we, 1);
      dmem_ack = 1;
      step();
      dmem_ack = 0;
      chk("bs_done", lsu2rob_done, 1);
      chk("bs_nocdb", cdb_req, 0);
      step();

      // signed byte load from lane 2
      drive_op(32'h300, 32'd2, 32'h0, 2'b00, 1, 0, 1, 6'd5, 6'd6);
      step();
      mem_issue_valid = 0;
      dmem_ack = 1; dmem_rdata = 32'h12F03456;
      step();
      dmem_ack = 0;
      chk("sb_data", cdb_data, 32'hFFFFFFF0);
      cdb_gnt = 1;
      step();
      cdb_gnt = 0;
      chk("sb_done", lsu2rob_done, 1);
      step();

      // misaligned word load
      drive_op(32'h100, 32'd2, 32'h0, 2'b10, 1, 0, 1, 6'd2, 6'd9);
      chk("ma_ready_pre", mem2iq_ready, 1);
      step();
      mem_issue_valid = 0;
      chk("ma_done", lsu2rob_done, 1);
      chk("ma_exc", lsu2rob_exc, 1);
      chk("ma_num", lsu2rob_num, 9);
      chk("ma_noreq", dmem_req, 0);
      chk("ma_ready", mem2iq_ready, 0);
      step();
      chk("ma_ready_post", mem2iq_ready, 1);
      chk("ma_done_post", lsu2rob_done, 0);

      // back-to-back offers with valid held high, first op wraps the address
      drive_op(32'hFFFFFFFC, 32'd8, 32'h11223344, 2'b10, 0, 1, 0, 6'd0, 6'd10);
      step();
      chk("bb_ready1", mem2iq_ready, 0);
      chk("bb_wrap", dmem_addr, 32'h4);
      drive_op(32'h20, 32'd0, 32'h55667788, 2'b10, 0, 1, 0, 6'd0, 6'd11);
      dmem_ack = 1;
      step();
      dmem_ack = 0;
      chk("bb_done1", lsu2rob_done, 1);
      chk("bb_ready_dn", mem2iq_ready, 0);
      step();
      chk("bb_ready2", mem2iq_ready, 1);
      step();
      mem_issue_valid = 0;
      chk("bb_addr2", dmem_addr, 32'h20);
      chk("bb_wdata2", dmem_wdata, 32'h55667788);
      dmem_ack = 1;
      step();
      dmem_ack = 0;
      chk("bb_num2", lsu2rob_num, 11);
      step();

      // reset while waiting for the CDB grant
      drive_op(32'h40, 32'd0, 32'h0, 2'b10, 1, 0, 1, 6'd12, 6'd13);
      step();
      mem_issue_valid = 0;
      dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
      step();
      dmem_ack = 0;
      chk("rs_cdb_pre", cdb_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rs_cdb_drop", cdb_req, 0);
      chk("rs_req", dmem_req, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rs_ready", mem2iq_ready, 1);
      for (int i = 0; i < 3; i++) begin
         chk("rs_nodone", lsu2rob_done, 0);
         step();
      end

      // randomized traffic
      done_before = n_done;
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] s1;
         s1 = $urandom;
         if ($urandom_range(0, 1) == 0) s1[1:0] = 2'b00;
         mem_issue_valid = ($urandom_range(0, 2) != 0);
         mem_scr1_data   = s1;
         mem_imm         = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
         mem_scr2_data   = $urandom;
         mem_size        = 2'($urandom_range(0, 3));
         mem_rd_en       = ($urandom_range(0, 3) != 0);
         mem_wr_en       = ($urandom_range(0, 1) == 0);
         mem_reg_write   = ($urandom_range(0, 3) != 0);
         mem_rd          = 6'($urandom);
         mem_rob_num     = 6'($urandom);
         dmem_ack        = ($urandom_range(0, 2) == 0);
         dmem_rdata      = $urandom;
         cdb_gnt         = ($urandom_range(0, 1) == 0);
         step();
      end
      mem_issue_valid = 0; dmem_ack = 1; cdb_gnt = 1;
      for (int i = 0; i < 10; i++) step();
      chk("rand_progress", (n_done - done_before >= 200) ? 1 : 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
